axi_burst_writer: RTL and testbench

Stream-to-AXI4 write master for the capture and DMA paths. It buffers one burst of stream beats internally, then issues an exact-length INCR burst. Bursts end early on `s_tlast`, never cross a 4 KB boundary, and wrap inside a configurable address region. Generation two of the stream-to-AXI writer: any power-of-two data width, variable burst length, region wrap, optional write-response checking.

---
 rtl/axi_wr_pkg.sv | 17 +
 rtl/axi_wr_beat_buf.sv | 40 ++++
 rtl/axi_burst_writer.sv | 193 +++++++++++++++++++
 tb/tb_axi_burst_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// rtl/axi_wr_pkg.sv - shared state type and AXI constants for the stream-to-AXI4 burst writer
package axi_wr_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [3:0]  CACHE_BUF   = 4'b0011;
  localparam int unsigned BOUNDARY_4K = 4096;
  localparam int unsigned AXI_ID_W    = 4;

endpackage

// File: rtl/axi_wr_beat_buf.sv
// rtl/axi_wr_beat_buf.sv - one-burst beat store, written at the fill count, read combinationally at the drain index
module axi_wr_beat_buf
  import axi_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int FLIP_BYTE  = 0,
  localparam int IDX_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                  i_clk,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MAX_BURST];
  logic [DATA_WIDTH-1:0] wr_beat;

  // Byte i of the stream beat lands in byte NB-1-i when flipping.
  for (genvar i = 0; i < NB; i++) begin : g_byte
    if (FLIP_BYTE != 0) begin : g_flip
      assign wr_beat[8*(NB-1-i) +: 8] = wr_data_i[8*i +: 8];
    end else begin : g_keep
      assign wr_beat[8*i +: 8] = wr_data_i[8*i +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_beat;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/axi_burst_writer.sv
// rtl/axi_burst_writer.sv - stream-to-AXI4 write master: buffers one burst, then issues an exact-length INCR burst
// Define AXI_WR_BRESP_EN to wait for each write response and count non-OKAY ones.
module axi_burst_writer
  import axi_wr_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    MAX_BURST    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int unsigned           REGION_BYTES = 65536,
  parameter int                    FLIP_BYTE    = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_W-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic [15:0]             o_err_cnt
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int AWSIZE = $clog2(BYTES);
  localparam int CNT_W  = $clog2(MAX_BURST) + 1;
  localparam int IDX_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [ADDR_WIDTH:0] REGION_END =
    (ADDR_WIDTH+1)'(BASE_ADDR) + (ADDR_WIDTH+1)'(REGION_BYTES);

  wr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [12:0]           lim_q;
  logic                  last_q, last_d;
  logic                  beat_we, s_acc, w_last, burst_done;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic [DATA_WIDTH-1:0] rd_beat;
  logic                  unused_b;

  // Beats that fit before the next 4 KB line, capped at MAX_BURST.
  function automatic logic [12:0] calc_lim(input logic [ADDR_WIDTH-1:0] a);
    logic [12:0] room;
    room = (13'(BOUNDARY_4K) - {1'b0, a[11:0]}) >> AWSIZE;
    return (room < 13'(MAX_BURST)) ? room : 13'(MAX_BURST);
  endfunction

  axi_wr_beat_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .FLIP_BYTE  (FLIP_BYTE)
  ) u_buf (
    .i_clk     (i_clk),
    .wr_en_i   (beat_we),
    .wr_idx_i  (cnt_q[IDX_W-1:0]),
    .wr_data_i (s_tdata),
    .rd_idx_i  (rd_q[IDX_W-1:0]),
    .rd_data_o (rd_beat)
  );

  // Gated by reset so ready reads low while the block is held in reset.
  assign s_tready = i_rst_n && (state_q == ST_FILL) && (13'(cnt_q) < lim_q);
  assign s_acc    = s_tvalid && s_tready;
  assign w_last   = (state_q == ST_W) && (13'(rd_q) == 13'(cnt_q) - 13'd1);
  assign addr_sum = {1'b0, addr_q} + ((ADDR_WIDTH+1)'(cnt_q) << AWSIZE);

  assign m_axi_awid    = '0;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awprot  = '0;
  assign m_axi_awqos   = '0;
  assign m_axi_awcache = CACHE_BUF;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awsize  = 3'(AWSIZE);
  assign m_axi_wstrb   = '1;
  assign m_axi_awvalid = (state_q == ST_AW);
  assign m_axi_awaddr  = m_axi_awvalid ? addr_q : '0;
  assign m_axi_awlen   = m_axi_awvalid ? 8'(13'(cnt_q) - 13'd1) : 8'd0;
  assign m_axi_wvalid  = (state_q == ST_W);
  assign m_axi_wdata   = rd_beat;
  assign m_axi_wlast   = w_last;
  assign o_busy        = (state_q != ST_FILL) || (cnt_q != '0);
  assign o_frame_done  = burst_done && last_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    last_d     = last_q;
    beat_we    = 1'b0;
    burst_done = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (s_acc) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if ((13'(cnt_q) + 13'd1 == lim_q) || s_tlast) begin
            state_d = ST_AW;
            last_d  = s_tlast;
          end
        end
      end
      ST_AW: begin
        if (m_axi_awready) state_d = ST_W;
      end
      ST_W: begin
        if (m_axi_wready) begin
          rd_d = rd_q + 1'b1;
          if (w_last) begin
            addr_d = (addr_sum == REGION_END) ? BASE_ADDR : addr_sum[ADDR_WIDTH-1:0];
            cnt_d  = '0;
            rd_d   = '0;
`ifdef AXI_WR_BRESP_EN
            state_d = ST_B;
`else
            state_d    = ST_FILL;
            burst_done = 1'b1;
`endif
          end
        end
      end
`ifdef AXI_WR_BRESP_EN
      ST_B: begin
        if (m_axi_bvalid) begin
          state_d    = ST_FILL;
          burst_done = 1'b1;
        end
      end
`endif
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      rd_q    <= '0;
      addr_q  <= BASE_ADDR;
      last_q  <= 1'b0;
      lim_q   <= calc_lim(BASE_ADDR);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      if ((state_d == ST_FILL) && (state_q != ST_FILL)) begin
        lim_q <= calc_lim(addr_d);
      end
    end
  end

`ifdef AXI_WR_BRESP_EN
  logic [15:0] err_q, err_d;

  assign m_axi_bready = (state_q == ST_B);
  assign err_d = (m_axi_bvalid && m_axi_bready && (m_axi_bresp != RESP_OKAY) &&
                  (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  assign o_err_cnt = err_q;
  assign unused_b  = ^m_axi_bid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= '0;
    else          err_q <= err_d;
  end
`else
  assign m_axi_bready = 1'b1;
  assign o_err_cnt    = 16'd0;
  assign unused_b     = ^{m_axi_bid, m_axi_bresp, m_axi_bvalid};
`endif

endmodule

// File: tb/tb_axi_burst_writer.sv
// tb/tb_axi_burst_writer.sv - random stream frames checked against a burst-splitting reference model
module tb_axi_burst_writer;

  localparam int          AW     = 32;
  localparam int          DW     = 64;
  localparam int          MB     = 16;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int unsigned REGION = 8192;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [3:0]    m_axi_awid;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awlock;
  logic [3:0]    m_axi_awcache;
  logic [2:0]    m_axi_awprot;
  logic [3:0]    m_axi_awqos;
  logic          m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [7:0]    m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [3:0]    m_axi_bid;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          o_busy, o_frame_done;
  logic [15:0]   o_err_cnt;

  always #5 i_clk = ~i_clk;

  axi_burst_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB),
    .BASE_ADDR(BASE), .REGION_BYTES(REGION), .FLIP_BYTE(0)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err_cnt(o_err_cnt)
  );

  typedef struct {
    int unsigned addr;
    int          n;
    bit          last;
  } burst_t;

  burst_t        bq[$];
  burst_t        cur;
  logic [DW-1:0] sq_data[$];
  bit            sq_last[$];
  logic [DW-1:0] exp_w[$];
  int unsigned   m_addr = BASE;
  int            vectors = 0, errors = 0;
  int            cyc = 0, beats_gen = 0, beat_target = 0;
  int            frames_gen = 0, frames_done = 0, beat = 0;
  bit            cur_active = 0, s_hs_q = 0, aw_pend_q = 0, b_pending = 0;
  logic [AW-1:0] held_addr;
  logic [7:0]    held_len;
`ifdef AXI_WR_BRESP_EN
  bit            b_last = 0, b_hs_q = 0, b_first = 1;
  int            b_wait = 0;
  logic [15:0]   exp_err = 0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: a frame splits into bursts that stop at tlast, at MB beats, or at a 4 KB line.
  task automatic gen_frame(input int len);
    int rem, room, n;
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      sq_data.push_back(d);
      sq_last.push_back(i == len - 1);
      exp_w.push_back(d);
    end
    rem = len;
    while (rem > 0) begin
      room = (4096 - (m_addr % 4096)) / (DW / 8);
      if (room > MB) room = MB;
      n = (rem < room) ? rem : room;
      bq.push_back('{addr: m_addr, n: n, last: (rem == n)});
      m_addr += n * (DW / 8);
      if (m_addr == BASE + REGION) m_addr = BASE;
      rem -= n;
    end
    beats_gen += len;
    frames_gen++;
  endtask

  function automatic bit idle();
    return (sq_data.size() == 0) && (bq.size() == 0) && !cur_active && !b_pending &&
           (beats_gen >= beat_target);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, s_tready, o_busy, o_frame_done,
                   m_axi_awaddr, m_axi_awlen, o_err_cnt}, 64'd0);
  endtask

  task automatic step();
    bit exp_fd;
    int len;
    logic [DW-1:0] d;
    @(negedge i_clk);
    cyc++;
    if (s_hs_q) begin
      void'(sq_data.pop_front());
      void'(sq_last.pop_front());
    end
    if (sq_data.size() == 0 && beats_gen < beat_target) begin
      case (frames_gen)
        0:       len = 32;
        1:       len = 5;
        2:       len = 16;
        default: len = $urandom_range(1, 40);
      endcase
      gen_frame(len);
    end
    if (!(s_tvalid && !s_hs_q)) s_tvalid = (sq_data.size() > 0) && ($urandom_range(0, 3) != 0);
    if (sq_data.size() > 0) begin
      s_tdata = sq_data[0];
      s_tlast = sq_last[0];
    end
    m_axi_awready = ($urandom_range(0, 3) == 0);
    m_axi_wready  = ($urandom_range(0, 1) == 1);
`ifdef AXI_WR_BRESP_EN
    if (b_hs_q) m_axi_bvalid = 1'b0;
    if (b_pending && !m_axi_bvalid) begin
      if (b_wait > 0) b_wait--;
      else begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (b_first || $urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
        b_first      = 0;
      end
    end
`endif
    #1;
    s_hs_q = s_tvalid && s_tready;
    exp_fd = 0;
    if (m_axi_awvalid || m_axi_wvalid) check_eq("tready_closed", s_tready, 0);
    if (m_axi_awvalid && aw_pend_q)
      check_eq("aw_stable", {m_axi_awaddr, m_axi_awlen}, {held_addr, held_len});
    aw_pend_q = m_axi_awvalid && !m_axi_awready;
    held_addr = m_axi_awaddr;
    held_len  = m_axi_awlen;
    if (m_axi_awvalid && m_axi_awready) begin
      check_eq("aw_overlap", cur_active, 0);
      check_eq("aw_busy", o_busy, 1);
`ifdef AXI_WR_BRESP_EN
      check_eq("aw_before_b", b_pending, 0);
      check_eq("err_cnt", o_err_cnt, exp_err);
`endif
      check_eq("aw_consts", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache,
                             m_axi_awprot, m_axi_awqos, m_axi_wstrb},
               {4'h0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 8'hFF});
      check_eq("aw_expected", bq.size() > 0, 1);
      if (bq.size() > 0) begin
        cur = bq.pop_front();
        cur_active = 1;
        beat = 0;
        check_eq("awaddr", m_axi_awaddr, cur.addr);
        check_eq("awlen", m_axi_awlen, cur.n - 1);
      end
    end
    if (m_axi_wvalid && m_axi_wready) begin
      check_eq("w_in_burst", cur_active, 1);
      if (cur_active) begin
        check_eq("w_expected", exp_w.size() > 0, 1);
        d = '0;
        if (exp_w.size() > 0) d = exp_w.pop_front();
        check_eq("wdata", m_axi_wdata, d);
        check_eq("wlast", m_axi_wlast, beat == cur.n - 1);
        beat++;
        if (beat == cur.n) begin
          cur_active = 0;
`ifdef AXI_WR_BRESP_EN
          b_pending = 1;
          b_last    = cur.last;
          b_wait    = $urandom_range(0, 4);
`else
          exp_fd = cur.last;
`endif
        end
      end
    end
`ifdef AXI_WR_BRESP_EN
    b_hs_q = m_axi_bvalid && m_axi_bready;
    if (b_hs_q) begin
      exp_fd    = b_last;
      b_pending = 0;
      if (m_axi_bresp != 2'b00 && exp_err != 16'hFFFF) exp_err++;
    end
`endif
    if (exp_fd || o_frame_done) check_eq("frame_done", o_frame_done, exp_fd);
    if (exp_fd) frames_done++;
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    while (!idle() && n < 30000) begin
      step();
      n++;
    end
    check_eq(tag, idle(), 1);
    step();
    check_eq("idle_busy", o_busy, 0);
    check_eq("frames_done", frames_done, frames_gen);
  endtask

  initial begin
    int n;
    s_tdata = '0; s_tvalid = 0; s_tlast = 0;
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bid = '0; m_axi_bresp = 2'b00; m_axi_bvalid = 0;
    repeat (3) @(negedge i_clk);
    #1;
    check_reset_outputs("reset_outputs");
`ifdef AXI_WR_BRESP_EN
    check_eq("reset_bready", m_axi_bready, 0);
`else
    check_eq("bready_tied", m_axi_bready, 1);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;

    beat_target = 1100;
    run_until_idle("traffic_done");
`ifdef AXI_WR_BRESP_EN
    check_eq("err_cnt_end", o_err_cnt, exp_err);
`else
    check_eq("err_cnt_tied", o_err_cnt, 0);
`endif

    gen_frame(12);
    n = 0;
    while (!(cur_active && beat >= 2) && n < 2000) begin
      step();
      n++;
    end
    check_eq("midw_reached", cur_active && beat >= 2, 1);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("midw_reset_outputs");
    sq_data.delete(); sq_last.delete(); exp_w.delete(); bq.delete();
    cur_active = 0; s_hs_q = 0; aw_pend_q = 0; b_pending = 0;
    s_tvalid = 0; m_axi_bvalid = 0;
    m_addr = BASE;
    frames_gen = frames_done;
`ifdef AXI_WR_BRESP_EN
    b_hs_q = 0; exp_err = 0;
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;

    gen_frame(20);
    run_until_idle("post_reset_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
